// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared state type, default widths and timer sizing for the FIFO read-side drain controller.
package fifo_rd_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} rd_state_e;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 16;
    // Timer width that fits the default BUSY_TIMEOUT=16 / GAP_CYCLES=4 reload values
    localparam int TMR_W_DEF      = 4;
    // Smallest width holding max(busy_timeout, gap_cycles)-1, the largest reload value
    function automatic int tmr_width(int busy_timeout, int gap_cycles);
        int m;
        m = busy_timeout > gap_cycles ? busy_timeout : gap_cycles;
        return m > 2 ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/fifo_rd_timer.sv
// fifo_rd_timer: loadable down-counter shared by the TX-start timeout and the inter-word gap.
// Ports: clk, rst (sync, active-high), load/load_val (load wins over dec),
//        dec (count down, saturates at 0), zero (counter is 0).
module fifo_rd_timer import fifo_rd_pkg::*; #(
    parameter int W = TMR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk)
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;

    assign zero = cnt == '0;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-clock-domain drain controller popping FIFO words into a UART TX.
// Ports: clk, rst (sync, active-high), en (drain enable), rd_data/empty (FIFO read side),
//        r_inc (pop strobe), tx_busy (UART busy), tx_p_data/tx_data_valid (word + strobe to TX),
//        word_cnt (completed TX words, wraps), timeout_err (sticky), clr_err (clears timeout_err).
// Optional: define FIFO_RD_GAP_EN to insert GAP_CYCLES idle cycles after every completed word.
module fifo_rd_ctrl import fifo_rd_pkg::*; #(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int BUSY_TIMEOUT = 16,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  empty,
    output logic                  r_inc,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_data_valid,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  timeout_err,
    input  logic                  clr_err
);
    localparam int TMR_W = tmr_width(BUSY_TIMEOUT, GAP_CYCLES);
    // Timer runs reload..0 inclusive, so each wait lasts reload+1 cycles
    localparam logic [TMR_W-1:0] BUSY_LD = TMR_W'(BUSY_TIMEOUT - 1);
`ifdef FIFO_RD_GAP_EN
    localparam logic [TMR_W-1:0] GAP_LD = TMR_W'(GAP_CYCLES - 1);
`else
    localparam logic [TMR_W-1:0] GAP_LD = '0;
`endif

    rd_state_e        state;
    logic             start, to_gap, tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0] tmr_val;

`ifdef FIFO_RD_GAP_EN
    assign to_gap = state == WAIT_DONE && !tx_busy;
`else
    assign to_gap = 1'b0;
`endif

    always_comb begin
        start    = state == IDLE && en && !empty && !tx_busy;
        tmr_load = start || to_gap || (state == WAIT_BUSY && tx_busy);
        tmr_val  = start ? BUSY_LD : to_gap ? GAP_LD : '0;
        tmr_dec  = state == WAIT_BUSY || state == GAP;
    end

    fifo_rd_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            r_inc         <= 1'b0;
            tx_data_valid <= 1'b0;
            tx_p_data     <= '0;
            word_cnt      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            r_inc         <= 1'b0;
            tx_data_valid <= 1'b0;
            // A timeout in the same cycle overrides this clear below
            if (clr_err)
                timeout_err <= 1'b0;
            case (state)
                IDLE:
                    if (start) begin
                        tx_p_data     <= rd_data;
                        r_inc         <= 1'b1;
                        tx_data_valid <= 1'b1;
                        state         <= WAIT_BUSY;
                    end
                WAIT_BUSY:
                    if (tx_busy)
                        state <= WAIT_DONE;
                    else if (tmr_zero) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                WAIT_DONE:
                    if (!tx_busy) begin
                        word_cnt <= word_cnt + 1'b1;
                        state    <= to_gap ? GAP : IDLE;
                    end
`ifdef FIFO_RD_GAP_EN
                GAP:
                    if (tmr_zero)
                        state <= IDLE;
`endif
                default:
                    state <= IDLE;
            endcase
        end
    end
endmodule
